// File: rtl/pov_frame_engine.sv
// pov_frame_engine: double-buffered POV pixel store.
// The CPU renders into the back buffer over a memory-mapped register window.
// The LED path scans the front buffer by angular column and LED index.
// A requested buffer swap commits only when theta wraps, so a frame never tears mid-rotation.
module pov_frame_engine #(
   parameter int          N_COLS  = 256,
   parameter int          N_LEDS  = 8,
   parameter int          THETA_W = 6,
   parameter logic [31:0] BASE    = 32'hFFFF0000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [31:0]               cpu_addr,
   input  logic [31:0]               cpu_data_in,
   input  logic                      cpu_wren,
   input  logic                      cpu_rden,
   output logic [31:0]               cpu_data_out,
   input  logic [THETA_W-1:0]        theta,
   input  logic [$clog2(N_LEDS)-1:0] led_idx,
   output logic [23:0]               pixel_color,
   output logic                      frame_swap
);

   localparam int COL_W  = $clog2(N_COLS);
   localparam int LED_W  = $clog2(N_LEDS);
   localparam int SHIFT  = COL_W - THETA_W;
   localparam int ADDR_W = 1 + COL_W + LED_W;

   typedef enum logic [4:0] {
      REG_COL       = 5'h00,
      REG_LED       = 5'h04,
      REG_PIXEL     = 5'h08,
      REG_STATUS    = 5'h0C,
      REG_CTRL      = 5'h10,
      REG_SWAP      = 5'h14,
      REG_FRAME_CNT = 5'h18
   } reg_ofs_e;

   logic [COL_W-1:0]   col_ptr;
   logic [LED_W-1:0]   led_ptr;
   logic               autoinc;
   logic               blank;
   logic               swap_pending;
   logic               front_sel;
   logic [31:0]        frame_cnt;
   logic [THETA_W-1:0] theta_prev;

   logic [31:0]        offset;
   logic               hit;
   logic [4:0]         ofs;
   logic [COL_W-1:0]   current_col;
   logic [7:0]         status_col;
   logic               boundary;
   logic               commit;
   logic               col_wr, led_wr, pix_wr, ctrl_wr, swap_wr;
   logic [31:0]        rd_data;
   logic               unused_data;

   logic [23:0]        pix_mem [2**ADDR_W];

   // Addresses below BASE wrap to a huge offset and fall out of the window.
   assign offset      = cpu_addr - BASE;
   assign hit         = (offset[31:5] == '0);
   assign ofs         = offset[4:0];
   assign current_col = COL_W'(theta) << SHIFT;
   assign status_col  = 8'(current_col);
   assign boundary    = (theta < theta_prev);
   assign commit      = boundary && swap_pending;
   assign unused_data = ^cpu_data_in[31:24];

   // Write strobe decode for the register window.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
      col_wr  = 1'b0;
      led_wr  = 1'b0;
      pix_wr  = 1'b0;
      ctrl_wr = 1'b0;
      swap_wr = 1'b0;
      if (cpu_wren && hit) begin
         case (ofs)
            REG_COL:   col_wr  = 1'b1;
            REG_LED:   led_wr  = 1'b1;
            REG_PIXEL: pix_wr  = 1'b1;
            REG_CTRL:  ctrl_wr = 1'b1;
            REG_SWAP:  swap_wr = 1'b1;
            default:   ;
         endcase
      end
   end

   // Read data mux; write-only and unmapped offsets read as zero.
   always_comb begin
      rd_data = '0;
      if (hit) begin
         case (ofs)
            REG_COL:       rd_data = 32'(col_ptr);
            REG_LED:       rd_data = 32'(led_ptr);
            REG_STATUS:    rd_data = {15'b0, swap_pending, 8'b0, status_col};
            REG_CTRL:      rd_data = {30'b0, blank, autoinc};
            REG_FRAME_CNT: rd_data = frame_cnt;
            default:       rd_data = '0;
         endcase
      end
   end

   // Control registers, render pointers and the swap/commit machinery.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         col_ptr      <= '0;
         led_ptr      <= '0;
         autoinc      <= 1'b0;
         blank        <= 1'b0;
         swap_pending <= 1'b0;
         front_sel    <= 1'b0;
         frame_cnt    <= '0;
         theta_prev   <= '0;
         frame_swap   <= 1'b0;
      end else begin
         theta_prev <= theta;
         frame_swap <= commit;
         if (commit) begin
            front_sel <= ~front_sel;
            frame_cnt <= frame_cnt + 32'd1;
         end
         // A SWAP write landing on a boundary stays pending for the next one.
         if (swap_wr)
            swap_pending <= 1'b1;
         else if (commit)
            swap_pending <= 1'b0;
         if (col_wr)
            col_ptr <= cpu_data_in[COL_W-1:0];
         if (led_wr)
            led_ptr <= cpu_data_in[LED_W-1:0];
         if (ctrl_wr) begin
            autoinc <= cpu_data_in[0];
            blank   <= cpu_data_in[1];
         end
         // Raster order: LED advances first, column advances when LED wraps.
         if (pix_wr && autoinc) begin
            led_ptr <= led_ptr + LED_W'(1);
            if (&led_ptr)
               col_ptr <= col_ptr + COL_W'(1);
         end
      end
   end

   // Back-buffer write port; front_sel is the pre-commit value, so a write
   // coincident with a commit lands in the buffer that is becoming front.
   always_ff @(posedge clk) begin
      // NOTE: pixel RAM is deliberately not reset so it maps onto block RAM; only control state resets.
      if (pix_wr)
         pix_mem[{~front_sel, col_ptr, led_ptr}] <= cpu_data_in[23:0];
   end

   // Front-buffer scan port with one cycle of latency; blank forces black.
   always_ff @(posedge clk) begin
      if (reset)
         pixel_color <= '0;
      else if (blank)
         pixel_color <= '0;
      else
         pixel_color <= pix_mem[{front_sel, current_col, led_idx}];
   end

   // Registered CPU read data, held while no read is in progress.
   always_ff @(posedge clk) begin
      if (reset)
         cpu_data_out <= '0;
      else if (cpu_rden)
         cpu_data_out <= rd_data;
   end

endmodule

// File: doc/pov_frame_engine.md
Name: pov_frame_engine

Overview:
- Parametrised, double-buffered successor to the single-colour-per-column POV peripheral.
- Holds N_COLS x N_LEDS 24-bit pixels per buffer. The CPU renders into the back buffer over the memory-mapped bus.
- The LED path scans the front buffer by angular position and LED index.
- Buffer swaps are requested by the CPU and take effect only at a revolution boundary, so no tearing occurs mid-rotation.

Parameters:
- N_COLS, 256, angular columns; power of 2; must be >= 2^THETA_W
- N_LEDS, 8, pixels per column; power of 2
- THETA_W, 6, width of the theta input
- BASE, 32'hFFFF0000, register base address

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cpu_addr  in  32  CPU address
- cpu_data_in  in  32  CPU write data
- cpu_wren  in  1  CPU write strobe
- cpu_rden  in  1  CPU read strobe
- cpu_data_out  out  32  CPU read data
- theta  in  THETA_W  angular position
- led_idx  in  log2(N_LEDS)  LED being refreshed by the strip driver
- pixel_color  out  24  front-buffer pixel at (current column, led_idx)
- frame_swap  out  1  one-cycle pulse when a buffer swap commits

Behaviour:
- Clock and reset: clk, synchronous active-high reset.
- Reset clears COL, LED, CTRL, swap_pending, front_sel (0), frame_cnt, theta_prev, cpu_data_out, pixel_color and frame_swap. Pixel RAM contents are not cleared.
- Register map (offsets from BASE; any other address: write ignored, read returns 0):
  - 0x00 COL (rw): column pointer, bits [log2 N_COLS-1:0].
  - 0x04 LED (rw): LED pointer.
  - 0x08 PIXEL (w): writes data[23:0] to back buffer at (COL, LED). With CTRL.autoinc=1, LED then increments. On LED wrap to 0, COL increments; COL wraps N_COLS-1 -> 0.
  - 0x0C STATUS (r): {15'b0, swap_pending, 8'b0, current_col[7:0]}. current_col is zero-extended/truncated to 8 bits.
  - 0x10 CTRL (rw): bit0 autoinc, bit1 blank. Blank forces pixel_color to 0.
  - 0x14 SWAP (w): any write sets swap_pending. A write while already pending has no additional effect.
  - 0x18 FRAME_CNT (r): 32-bit count of committed swaps, wraps.
- Back buffer is the buffer with index !front_sel.
- COL/LED writes take the low bits of data only; upper data bits are ignored.
- Pointers are always in range by construction.
- Column mapping: current_col = theta << (log2(N_COLS) - THETA_W).
- Revolution boundary: a cycle where theta < theta_prev. theta_prev is registered every cycle.
- Swap commit: on a boundary cycle with swap_pending=1, the following happen on the same clock edge:
  - front_sel toggles
  - swap_pending clears
  - frame_cnt increments
  - frame_swap=1 for exactly that one cycle
- Boundary with no pending swap: nothing happens.
- SWAP write coincident with boundary: the pending flag is set. The commit waits for the next boundary.
- PIXEL write coincident with commit: the write lands in the pre-commit back buffer, which becomes the front buffer. Firmware must sequence writes before issuing SWAP.
- pixel_color latency: 1 cycle from theta/led_idx change. It reads the front buffer selected by front_sel as registered at that edge.
- cpu_data_out latency: 1 cycle after cpu_rden; holds its value when rden=0.
- Simultaneous wren and rden to the same register: the read returns the pre-write value.
- Reset mid-render: all pointers return to 0 and any pending swap is discarded. The buffer holding front_sel=0 becomes front.

Test Plan:
- Autoinc fill: reset, write CTRL=1, COL=0, LED=0, then 2*N_LEDS PIXEL writes with values 1..16 -> back buffer (0,0..7)=1..8 and (1,0..7)=9..16; COL reads back 2, LED reads back 0.
- Swap at boundary: fill back (4,3)=0xFF0000, write SWAP, STATUS bit16=1; sweep theta 62,63,0 -> frame_swap pulses one cycle at theta=0; FRAME_CNT=1; theta=1, led_idx=3 -> pixel_color=0xFF0000 one cycle later.
- No tearing: with swap pending, hold theta constant or increasing over 50 cycles -> front_sel is unchanged and pixel_color keeps the old frame.
- Pointer wrap: COL=N_COLS-1, LED=N_LEDS-1, autoinc, one PIXEL write -> COL=0, LED=0.
- Blank and unmapped: CTRL=2 -> pixel_color=0 regardless of contents; read BASE+0x20 -> 0; write BASE+0x20 -> no register changes.
- Reset mid-pending: SWAP written, then reset asserted one cycle -> STATUS=0, FRAME_CNT=0, and no frame_swap at the next boundary.
